// File: rtl/pht_update_scheduler_pkg.sv
// Shared PHT types, sizing constants and the saturating counter step used by
// the update scheduler and the predictors.
package pht_update_scheduler_pkg;

  localparam int unsigned PHT_ENTRY_NUM   = 2048;
  localparam int unsigned PHT_INDEX_WIDTH = 11;
  localparam int unsigned PHT_CNT_WIDTH   = 2;
  localparam int unsigned COMMIT_WIDTH    = 2;
  localparam int unsigned QUEUE_DEPTH     = 4;
  localparam int unsigned QUEUE_PTR_WIDTH = $clog2(QUEUE_DEPTH);
  localparam int unsigned QUEUE_CNT_WIDTH = $clog2(QUEUE_DEPTH + 1);

  typedef logic [PHT_INDEX_WIDTH-1:0] pht_index_t;
  typedef logic [PHT_CNT_WIDTH-1:0]   pht_cnt_t;

  // Weakly-not-taken value written by the initialisation sweep.
  localparam pht_cnt_t PHT_INIT_VALUE = 2'b01;

  typedef struct packed {
    pht_index_t index;
    pht_cnt_t   cnt;
  } pht_update_entry_t;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } sched_state_t;

  // One saturating step of a 2-bit counter in the resolved direction.
  function automatic pht_cnt_t pht_sat_step(input pht_cnt_t cnt, input logic taken);
    pht_cnt_t res;
    if (taken) res = (cnt == 2'd3) ? 2'd3 : cnt + 2'd1;
    else       res = (cnt == 2'd0) ? 2'd0 : cnt - 2'd1;
    return res;
  endfunction

endpackage

// File: rtl/pht_update_scheduler_if.sv
// Commit-side update bus plus PHT write port of the update scheduler.
//   upd_valid/upd_index/upd_taken/upd_old_cnt : per-lane update requests
//   upd_ready_c : whole commit group accepted this cycle
//   pht_we_c/pht_waddr_c/pht_wdata_c : PHT write port
//   init_busy_c : initialisation sweep in progress
// master = commit source / PHT consumer, slave = scheduler.
interface pht_update_scheduler_if;
  import pht_update_scheduler_pkg::*;

  logic [COMMIT_WIDTH-1:0]              upd_valid;
  pht_index_t [COMMIT_WIDTH-1:0]        upd_index;
  logic [COMMIT_WIDTH-1:0]              upd_taken;
  pht_cnt_t [COMMIT_WIDTH-1:0]          upd_old_cnt;
  logic                                 upd_ready_c;
  logic                                 pht_we_c;
  pht_index_t                           pht_waddr_c;
  pht_cnt_t                             pht_wdata_c;
  logic                                 init_busy_c;

  modport master (
    output upd_valid, upd_index, upd_taken, upd_old_cnt,
    input  upd_ready_c, pht_we_c, pht_waddr_c, pht_wdata_c, init_busy_c
  );

  modport slave (
    input  upd_valid, upd_index, upd_taken, upd_old_cnt,
    output upd_ready_c, pht_we_c, pht_waddr_c, pht_wdata_c, init_busy_c
  );

endinterface

// File: rtl/pht_update_queue.sv
// Multi-push, single-pop circular buffer of pending PHT updates.
//   clk, rst (async, active-low)
//   push_valid/push_entry : lanes to enqueue, lane 0 first, invalid lanes leave no gap
//   push_taken            : lane direction, only with RSD_PHT_UPDATE_MERGE_EN
//   pop                   : drop head entry at this edge
//   head_entry_c, count   : oldest entry and occupancy
// With RSD_PHT_UPDATE_MERGE_EN defined, a lane whose index already sits in a
// non-head slot folds into that slot instead of allocating a new one.
module pht_update_queue
  import pht_update_scheduler_pkg::*;
(
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [COMMIT_WIDTH-1:0]              push_valid,
  input  pht_update_entry_t [COMMIT_WIDTH-1:0] push_entry,
`ifdef RSD_PHT_UPDATE_MERGE_EN
  input  logic [COMMIT_WIDTH-1:0]              push_taken,
`endif
  input  logic                                 pop,
  output pht_update_entry_t                    head_entry_c,
  output logic [QUEUE_CNT_WIDTH-1:0]           count
);

  pht_update_entry_t            mem_q [QUEUE_DEPTH];
  pht_update_entry_t            mem_d [QUEUE_DEPTH];
  logic [QUEUE_PTR_WIDTH-1:0]   head_q, head_d;
  logic [QUEUE_PTR_WIDTH-1:0]   tail_q, tail_d;
  logic [QUEUE_CNT_WIDTH-1:0]   count_q, count_d;
  logic [QUEUE_CNT_WIDTH-1:0]   alloc;
`ifdef RSD_PHT_UPDATE_MERGE_EN
  logic                         merged;
  logic [QUEUE_PTR_WIDTH-1:0]   slot;
  logic [QUEUE_CNT_WIDTH-1:0]   occ;
`endif

  // Enqueue lanes in order; the head slot is never a merge target while it is
  // being popped, but a slot allocated this cycle into an empty queue is.
  always_comb begin
    mem_d = mem_q;
    alloc = '0;
`ifdef RSD_PHT_UPDATE_MERGE_EN
    merged = 1'b0;
    slot   = '0;
    occ    = '0;
`endif
    for (int i = 0; i < int'(COMMIT_WIDTH); i++) begin
      if (push_valid[i]) begin
`ifdef RSD_PHT_UPDATE_MERGE_EN
        merged = 1'b0;
        occ    = count_q + alloc;
        for (int k = 0; k < int'(QUEUE_DEPTH); k++) begin
          slot = head_q + QUEUE_PTR_WIDTH'(k);
          if (!merged && (QUEUE_CNT_WIDTH'(k) < occ) && !(k == 0 && count_q != '0) &&
              (mem_d[slot].index == push_entry[i].index)) begin
            mem_d[slot].cnt = pht_sat_step(mem_d[slot].cnt, push_taken[i]);
            merged = 1'b1;
          end
        end
        if (!merged) begin
          mem_d[tail_q + QUEUE_PTR_WIDTH'(alloc)] = push_entry[i];
          alloc = alloc + QUEUE_CNT_WIDTH'(1);
        end
`else
        mem_d[tail_q + QUEUE_PTR_WIDTH'(alloc)] = push_entry[i];
        alloc = alloc + QUEUE_CNT_WIDTH'(1);
`endif
      end
    end
    head_d  = head_q + QUEUE_PTR_WIDTH'(pop);
    tail_d  = tail_q + QUEUE_PTR_WIDTH'(alloc);
    count_d = count_q + alloc - QUEUE_CNT_WIDTH'(pop);
  end

  // Pointer, occupancy and storage registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int j = 0; j < int'(QUEUE_DEPTH); j++) mem_q[j] <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      for (int j = 0; j < int'(QUEUE_DEPTH); j++) mem_q[j] <= mem_d[j];
    end
  end

  assign head_entry_c = mem_q[head_q];
  assign count        = count_q;

endmodule

// File: rtl/pht_update_scheduler.sv
// Owns the PHT write port: runs a full-table init sweep after reset, then
// buffers commit-stage counter updates and drains them one per cycle.
//   clk, rst (async, active-low)
//   bus (slave) : update lanes in, upd_ready_c / PHT write port / init_busy_c out
//   PHT_ENTRIES : table size swept at init (power of two, <= PHT_ENTRY_NUM)
// Optional RSD_PHT_UPDATE_MERGE_EN folds repeated in-flight indices in the queue.
module pht_update_scheduler
  import pht_update_scheduler_pkg::*;
#(
  parameter int unsigned PHT_ENTRIES = PHT_ENTRY_NUM
)
(
  input  logic                   clk,
  input  logic                   rst,
  pht_update_scheduler_if.slave  bus
);

  localparam pht_index_t SWEEP_LAST = PHT_INDEX_WIDTH'(PHT_ENTRIES - 1);
  localparam logic [QUEUE_CNT_WIDTH-1:0] READY_MAX_CNT =
    QUEUE_CNT_WIDTH'(QUEUE_DEPTH - COMMIT_WIDTH);

  sched_state_t                         state_q, state_d;
  pht_index_t                           sweep_q, sweep_d;
  logic [QUEUE_CNT_WIDTH-1:0]           q_count;
  pht_update_entry_t                    q_head_c;
  logic [COMMIT_WIDTH-1:0]              push_valid_c;
  pht_update_entry_t [COMMIT_WIDTH-1:0] push_entry_c;
  logic                                 pop_c;
  logic                                 ready_c;

  // State and sweep index registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_INIT;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
    end
  end

  // Next state, sweep stepping and PHT write-port muxing.
  always_comb begin
    state_d         = state_q;
    sweep_d         = sweep_q;
    ready_c         = 1'b0;
    push_valid_c    = '0;
    pop_c           = 1'b0;
    bus.pht_we_c    = 1'b0;
    bus.pht_waddr_c = '0;
    bus.pht_wdata_c = '0;
    bus.init_busy_c = 1'b0;
    case (state_q)
      ST_INIT: begin
        bus.init_busy_c = 1'b1;
        bus.pht_we_c    = 1'b1;
        bus.pht_waddr_c = sweep_q;
        bus.pht_wdata_c = PHT_INIT_VALUE;
        sweep_d         = sweep_q + PHT_INDEX_WIDTH'(1);
        if (sweep_q == SWEEP_LAST) begin
          state_d = ST_RUN;
          sweep_d = '0;
        end
      end
      ST_RUN: begin
        // Conservative: a same-cycle pop is not credited.
        ready_c      = (q_count <= READY_MAX_CNT);
        push_valid_c = bus.upd_valid & {COMMIT_WIDTH{ready_c}};
        if (q_count != '0) begin
          bus.pht_we_c    = 1'b1;
          bus.pht_waddr_c = q_head_c.index;
          bus.pht_wdata_c = q_head_c.cnt;
          pop_c           = 1'b1;
        end
      end
    endcase
  end

  assign bus.upd_ready_c = ready_c;

  // New counter value is resolved at enqueue time.
  always_comb begin
    push_entry_c = '0;
    for (int i = 0; i < int'(COMMIT_WIDTH); i++) begin
      push_entry_c[i].index = bus.upd_index[i];
      push_entry_c[i].cnt   = pht_sat_step(bus.upd_old_cnt[i], bus.upd_taken[i]);
    end
  end

  pht_update_queue u_queue (
    .clk          (clk),
    .rst          (rst),
    .push_valid   (push_valid_c),
    .push_entry   (push_entry_c),
`ifdef RSD_PHT_UPDATE_MERGE_EN
    .push_taken   (bus.upd_taken),
`endif
    .pop          (pop_c),
    .head_entry_c (q_head_c),
    .count        (q_count)
  );

endmodule

// File: tb/tb_pht_update_scheduler.sv
// Scoreboard bench for pht_update_scheduler with a 16-entry table.
module tb_pht_update_scheduler;
  import pht_update_scheduler_pkg::*;

  typedef struct {
    int addr;
    int data;
    int busy;
  } exp_t;

  typedef struct {
    logic [1:0] v;
    int i0; logic t0; int o0; int e0;
    int i1; logic t1; int o1; int e1;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  pht_update_scheduler_if bus();

  pht_update_scheduler #(.PHT_ENTRIES(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Monitor: every committed write must match the next expected write.
  always @(negedge clk) begin
    if (rst && bus.pht_we_c) begin
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write got addr=%0d data=%0d busy=%0d, none expected",
                 bus.pht_waddr_c, bus.pht_wdata_c, bus.init_busy_c);
      end else begin
        e = sb.pop_front();
        if (int'(bus.pht_waddr_c) != e.addr || int'(bus.pht_wdata_c) != e.data ||
            int'(bus.init_busy_c) != e.busy) begin
          errors++;
          $display("FAIL pht_write got addr=%0d data=%0d busy=%0d expected addr=%0d data=%0d busy=%0d",
                   bus.pht_waddr_c, bus.pht_wdata_c, bus.init_busy_c, e.addr, e.data, e.busy);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_exp(input int addr, input int data, input int busy);
    exp_t e;
    e.addr = addr; e.data = data; e.busy = busy;
    sb.push_back(e);
  endtask

  task automatic expect_sweep(input int n);
    for (int i = 0; i < n; i++) push_exp(i, 1, 1);
  endtask

  function automatic vec_t mk(input logic [1:0] v,
                              input int i0, input logic t0, input int o0, input int e0,
                              input int i1, input logic t1, input int o1, input int e1);
    vec_t r;
    r.v = v;
    r.i0 = i0; r.t0 = t0; r.o0 = o0; r.e0 = e0;
    r.i1 = i1; r.t1 = t1; r.o1 = o1; r.e1 = e1;
    return r;
  endfunction

  // Hold the group until ready, optionally queue its expected writes, then release.
  task automatic send_group(input vec_t g, input bit track);
    bit done = 0;
    bus.upd_valid      = g.v;
    bus.upd_index[0]   = PHT_INDEX_WIDTH'(g.i0);
    bus.upd_taken[0]   = g.t0;
    bus.upd_old_cnt[0] = 2'(g.o0);
    bus.upd_index[1]   = PHT_INDEX_WIDTH'(g.i1);
    bus.upd_taken[1]   = g.t1;
    bus.upd_old_cnt[1] = 2'(g.o1);
    for (int c = 0; c < 50 && !done; c++) begin
      if (bus.upd_ready_c) begin
        if (track && g.v[0]) push_exp(g.i0, g.e0, 0);
        if (track && g.v[1]) push_exp(g.i1, g.e1, 0);
        done = 1;
      end
      tick();
    end
    bus.upd_valid = '0;
    if (!done) check("send_group_timeout", 0, 1);
  endtask

  task automatic wait_drain(input string name);
    for (int c = 0; c < 40 && (sb.size() != 0 || bus.pht_we_c); c++) tick();
    check(name, sb.size(), 0);
  endtask

  vec_t burst[4];

  initial begin
    bus.upd_valid   = '0;
    bus.upd_index   = '0;
    bus.upd_taken   = '0;
    bus.upd_old_cnt = '0;

    // Outputs held in reset.
    tick(); tick();
    check("rst_init_busy", bus.init_busy_c, 1);
    check("rst_upd_ready", bus.upd_ready_c, 0);
    check("rst_pht_we",    bus.pht_we_c, 1);
    check("rst_pht_waddr", bus.pht_waddr_c, 0);
    check("rst_pht_wdata", bus.pht_wdata_c, 1);

    // Full sweep after release, with updValid asserted but ignored.
    expect_sweep(16);
    rst = 1'b1;
    bus.upd_valid = 2'b11;
    check("sweep_ready_low", bus.upd_ready_c, 0);
    for (int i = 0; i < 16; i++) tick();
    bus.upd_valid = '0;
    check("run_init_busy", bus.init_busy_c, 0);
    check("run_upd_ready", bus.upd_ready_c, 1);
    check("run_idle_we",   bus.pht_we_c, 0);
    check("sweep_consumed", sb.size(), 0);

    // Single group, one-cycle latency then lane order.
    send_group(mk(2'b11, 5, 1'b1, 3, 3, 7, 1'b0, 0, 0), 1);
    check("lat_we",    bus.pht_we_c, 1);
    check("lat_addr0", bus.pht_waddr_c, 5);
    tick();
    check("lat_addr1", bus.pht_waddr_c, 7);
    wait_drain("drain_single");

    // Back-to-back groups fill the queue; last group has only lane 1 valid.
    burst[0] = mk(2'b11, 1, 1'b1, 0, 1, 2, 1'b0, 2, 1);
    burst[1] = mk(2'b11, 3, 1'b1, 2, 3, 4, 1'b0, 1, 0);
    burst[2] = mk(2'b11, 6, 1'b1, 3, 3, 8, 1'b0, 0, 0);
    burst[3] = mk(2'b10, 0, 1'b1, 0, 0, 9, 1'b1, 1, 2);
    for (int g = 0; g < 4; g++) begin
      if (g == 2) check("full_ready_low", bus.upd_ready_c, 0);
      send_group(burst[g], 1);
    end
    wait_drain("drain_burst");

    // Repeated index queued behind a head entry.
    push_exp(10, 1, 0);
`ifdef RSD_PHT_UPDATE_MERGE_EN
    push_exp(4, 3, 0);
`else
    push_exp(4, 2, 0);
    push_exp(4, 2, 0);
`endif
    send_group(mk(2'b11, 10, 1'b1, 0, 1, 4, 1'b1, 1, 2), 0);
    send_group(mk(2'b01, 4, 1'b1, 1, 2, 0, 1'b0, 0, 0), 0);
    wait_drain("drain_merge");

    // Reset mid-sweep at index 9.
    rst = 1'b0;
    tick(); tick();
    expect_sweep(9);
    rst = 1'b1;
    for (int i = 0; i < 9; i++) tick();
    rst = 1'b0;
    #1;
    check("midsweep_consumed", sb.size(), 0);
    check("midsweep_rst_addr", bus.pht_waddr_c, 0);
    check("midsweep_rst_busy", bus.init_busy_c, 1);
    tick(); tick();
    expect_sweep(16);
    rst = 1'b1;
    for (int i = 0; i < 16; i++) tick();
    check("resweep_busy", bus.init_busy_c, 0);
    check("resweep_consumed", sb.size(), 0);

    // Reset with three entries still queued: none of them may be written.
    push_exp(11, 3, 0);
    send_group(mk(2'b11, 11, 1'b1, 2, 3, 12, 1'b0, 3, 2), 0);
    send_group(mk(2'b11, 13, 1'b1, 0, 1, 14, 1'b0, 2, 1), 0);
    rst = 1'b0;
    #1;
    check("flush_first_written", sb.size(), 0);
    tick(); tick();
    expect_sweep(16);
    rst = 1'b1;
    for (int i = 0; i < 16; i++) tick();
    check("flush_ready", bus.upd_ready_c, 1);
    for (int i = 0; i < 5; i++) tick();
    check("flush_idle_we", bus.pht_we_c, 0);
    check("flush_consumed", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pht_update_scheduler.md
Name: pht_update_scheduler

Overview:
- Owns the single write port of the branch predictor's pattern history table (PHT).
- After reset, sequences a full-table initialisation sweep.
- Then accepts per-lane counter updates from the commit stage into a small buffer and drains them at one write per cycle.
- Sits between commit/recovery logic and the PHT RAM used by the GAg/Gshare/Bimodal predictors; it back-pressures commit when the buffer cannot absorb a commit group.

Parameters:
- PHT_ENTRY_NUM, 2048, number of PHT entries (power of two).
- PHT_INDEX_WIDTH, 11, log2(PHT_ENTRY_NUM).
- COMMIT_WIDTH, 2, update lanes per cycle.
- QUEUE_DEPTH, 4, buffered updates (power of two, >= COMMIT_WIDTH).
- PHT_INIT_VALUE, 2'b01, weakly-not-taken counter written during the sweep.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- updValid  in  COMMIT_WIDTH  per-lane update request.
- updIndex  in  COMMIT_WIDTH x PHT_INDEX_WIDTH  PHT index used at prediction time.
- updTaken  in  COMMIT_WIDTH  resolved branch direction.
- updOldCnt  in  COMMIT_WIDTH x 2  counter value read at prediction time.
- updReady  out  1  whole commit group can be accepted this cycle.
- phtWE  out  1  PHT write enable.
- phtWAddr  out  PHT_INDEX_WIDTH  PHT write address.
- phtWData  out  2  PHT write data.
- initBusy  out  1  sweep in progress; fetch must treat predictions as not-taken.

Behaviour:
- States:
  - INIT: sweep. Reset state.
  - RUN: normal operation.
- Reset values:
  - state=INIT, sweepIdx=0, queue empty (head=tail=count=0).
  - Outputs while in reset: initBusy=1, updReady=0, phtWE=1, phtWAddr=0, phtWData=PHT_INIT_VALUE. The write is only committed on a clock edge, so asserting phtWE during reset is harmless.
- INIT:
  - Each cycle: phtWE=1, phtWAddr=sweepIdx, phtWData=PHT_INIT_VALUE, then sweepIdx++.
  - On the edge that writes index PHT_ENTRY_NUM-1, go to RUN. The sweep takes exactly PHT_ENTRY_NUM cycles.
  - updReady=0 throughout; updValid is ignored.
- RUN:
  - initBusy=0.
  - updReady = (QUEUE_DEPTH - count) >= COMMIT_WIDTH. Computed from registered count only; a same-cycle pop is not credited.
  - Acceptance is all-or-nothing. When updReady=1, every valid lane is enqueued in lane order (lane 0 first). Invalid lanes are skipped and leave no gap.
  - When updReady=0, updValid must be held by the source; the block does not latch it.
- Stored value is computed at enqueue as the saturating step:
  - taken: min(3, old+1).
  - not taken: max(0, old-1).
  - Each entry holds {index, newCnt}.
- Drain:
  - If count>0: phtWE=1, phtWAddr/phtWData = head entry, pop at the clock edge.
  - Otherwise phtWE=0, phtWAddr/phtWData=0.
  - Minimum latency is 1 cycle: accepted at edge t, written during cycle t+1.
- Push and pop in the same cycle are both performed: count += pushes - pop. Pointers wrap modulo QUEUE_DEPTH.
- Queue full: updReady=0 and draining continues. Empty: no write.
- Same index in flight, without the optional feature: entries are written in order and the last write wins. Counter staleness is accepted.
- Asynchronous reset asserted mid-sweep or mid-drain: pending updates are discarded and the block returns to INIT with sweepIdx=0.

Optional Feature:
- Macro: RSD_PHT_UPDATE_MERGE_EN.
- When defined, on enqueue each valid lane compares its index against all occupied entries except the head (the head is always being popped).
- On a match, no new entry is allocated. The matching entry's stored newCnt takes one further saturating step in the lane's direction.
- Lane 1 matching lane 0's index in the same cycle merges into lane 0's newly allocated slot.
- updReady is unchanged (still conservative).
- When undefined, no comparators exist and every valid lane allocates an entry.

Decomposition:
- FetchUnitTypes gets:
  - PHT_ENTRY_NUM / PHT_INDEX_WIDTH constants.
  - PHT_IndexPath and PHT_CounterPath typedefs.
  - PHT_UpdateEntry struct {index, cnt}.
  - A saturating-step function shared with the predictors.
- The buffer is a natural sub-module, pht_update_queue: multi-push, single-pop circular FIFO with occupancy count and, under the macro, a merge port.
- pht_update_scheduler keeps the FSM, sweep counter and output muxing.

Test Plan (PHT_ENTRY_NUM=16, QUEUE_DEPTH=4, COMMIT_WIDTH=2):
- Reset release, no updates -> 16 consecutive writes, addr 0..15, data 2'b01, initBusy=1; then initBusy=0, updReady=1, phtWE=0.
- After init, lane0 {idx 5, taken, old 3} + lane1 {idx 7, not taken, old 0} -> next cycle write (5,3), following cycle write (7,0).
- Two lanes valid for 3 consecutive cycles -> updReady drops to 0 after the second group (count 4, or 3 after a pop); writes emerge in exact lane/arrival order with no loss.
- Async reset asserted at sweep index 9, released -> sweep restarts at 0 and runs for 16 cycles; no stale writes.
- Async reset asserted with 3 queued entries -> queue empty after release, sweep reruns, no queued data is ever written.
- Macro on: idx 4 {taken, old 1} queued behind a head entry, then idx 4 {taken, old 1} again -> a single write (4,3) after the head; without the macro, two writes (4,2),(4,2).
